// File: rtl/game_ctrl.sv
// game_ctrl: central sequencer for the dinosaur runner.
// Runs the IDLE/RUN/DEAD state machine. In RUN it counts frames into score
// points and score points into speed steps. It latches dinosaur/obstacle pixel
// overlap and ends the game at the closing frame tick. It also keeps the high
// score. Frame timing is taken from the falling edge of the VGA vertical sync.
module game_ctrl #(
    parameter int         FRAMES_PER_POINT = 6,
    parameter int         POINTS_PER_SPEED = 50,
    parameter logic [3:0] SPEED_INIT       = 4'd1,
    parameter logic [3:0] SPEED_MAX        = 4'd12,
    parameter int         DEAD_HOLD        = 60
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic        vs,
    input  logic        px_dinosaur,
    input  logic        px_obstacle,
    output logic        game_status,
    output logic        game_over,
    output logic [3:0]  speed,
    output logic [15:0] score,
    output logic [15:0] high_score
);

    // Counter widths; guarded so a parameter of 1 still yields a 1-bit counter.
    localparam int FW = (FRAMES_PER_POINT > 1) ? $clog2(FRAMES_PER_POINT) : 1;
    localparam int PW = (POINTS_PER_SPEED > 1) ? $clog2(POINTS_PER_SPEED) : 1;
    // The dead counter must be able to hold DEAD_HOLD itself.
    localparam int DW = $clog2(DEAD_HOLD + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DEAD = 2'd2
    } state_t;

    state_t          state_reg;
    logic            start_q;
    logic            vs_q;
    logic            hit_flag_reg;
    logic [FW-1:0]   frame_cnt_reg;
    logic [PW-1:0]   pt_cnt_reg;
    logic [DW-1:0]   dead_cnt_reg;

    logic start_rise;
    logic frame_tick;
    logic hit_now;
    logic dead_release;
    logic go_run;

    // Edge detection, overlap detection and the restart condition.
    always_comb begin
        start_rise   = START & ~start_q;
        frame_tick   = vs_q & ~vs;
        hit_now      = px_dinosaur & px_obstacle;
        dead_release = (dead_cnt_reg == DW'(DEAD_HOLD));
        go_run       = start_rise &
                       ((state_reg == ST_IDLE) ||
                        ((state_reg == ST_DEAD) && dead_release));
    end

    // Game state machine with registered outputs, counters and score keeping.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg     <= ST_IDLE;
            // Reset the edge detectors high so a level held through reset
            // produces no pulse on the first cycle.
            start_q       <= 1'b1;
            vs_q          <= 1'b1;
            hit_flag_reg  <= 1'b0;
            frame_cnt_reg <= '0;
            pt_cnt_reg    <= '0;
            dead_cnt_reg  <= '0;
            game_status   <= 1'b0;
            game_over     <= 1'b0;
            speed         <= SPEED_INIT;
            score         <= 16'd0;
            high_score    <= 16'd0;
        end else begin
            start_q <= START;
            vs_q    <= vs;

            if (go_run) begin
                // Start from IDLE, or restart from DEAD after the hold time.
                state_reg     <= ST_RUN;
                game_status   <= 1'b1;
                game_over     <= 1'b0;
                score         <= 16'd0;
                frame_cnt_reg <= '0;
                pt_cnt_reg    <= '0;
                dead_cnt_reg  <= '0;
                hit_flag_reg  <= 1'b0;
                speed         <= SPEED_INIT;
            end else begin
                case (state_reg)
                    ST_RUN: begin
                        if (frame_tick) begin
                            hit_flag_reg <= 1'b0;
                            if (hit_flag_reg || hit_now) begin
                                // A collision takes priority over the score step.
                                state_reg    <= ST_DEAD;
                                game_status  <= 1'b0;
                                game_over    <= 1'b1;
                                dead_cnt_reg <= '0;
                                if (score > high_score) begin
                                    high_score <= score;
                                end
                            end else if (frame_cnt_reg == FW'(FRAMES_PER_POINT - 1)) begin
                                frame_cnt_reg <= '0;
                                if (score != 16'hFFFF) begin
                                    score <= score + 16'd1;
                                end
                                if (pt_cnt_reg == PW'(POINTS_PER_SPEED - 1)) begin
                                    pt_cnt_reg <= '0;
                                    if (speed < SPEED_MAX) begin
                                        speed <= speed + 4'd1;
                                    end
                                end else begin
                                    pt_cnt_reg <= pt_cnt_reg + PW'(1);
                                end
                            end else begin
                                frame_cnt_reg <= frame_cnt_reg + FW'(1);
                            end
                        end else begin
                            hit_flag_reg <= hit_flag_reg | hit_now;
                        end
                    end
                    ST_DEAD: begin
                        hit_flag_reg <= 1'b0;
                        if (frame_tick && !dead_release) begin
                            dead_cnt_reg <= dead_cnt_reg + DW'(1);
                        end
                    end
                    default: begin
                        hit_flag_reg <= 1'b0;
                        state_reg    <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: directed vector bench for game_ctrl.
// A table of operations with hand-computed expected outputs is applied in a
// loop. Hand-written sequences follow for reset edge masking, start latency,
// collision coincident with the frame tick, and a START held across a restart.
module tb_game_ctrl;

    logic        CLK;
    logic        RESET;
    logic        START;
    logic        vs;
    logic        px_dinosaur;
    logic        px_obstacle;
    logic        game_status;
    logic        game_over;
    logic [3:0]  speed;
    logic [15:0] score;
    logic [15:0] high_score;

    int n_tests;
    int n_fail;

    game_ctrl dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .START       (START),
        .vs          (vs),
        .px_dinosaur (px_dinosaur),
        .px_obstacle (px_obstacle),
        .game_status (game_status),
        .game_over   (game_over),
        .speed       (speed),
        .score       (score),
        .high_score  (high_score)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    localparam int OP_RST    = 0;
    localparam int OP_PRESS  = 1;
    localparam int OP_FRAMES = 2;
    localparam int OP_HIT    = 3;
    localparam int NVEC      = 22;

    typedef struct {
        int          op;
        int          arg;
        logic        st;
        logic        ov;
        logic [3:0]  sp;
        logic [15:0] sc;
        logic [15:0] hi;
    } vec_t;

    vec_t vecs [NVEC];

    // One clock, then settle past the edge before sampling or driving.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Each frame: vs low for one cycle, then high for three.
    task automatic do_frames(input int n);
        for (int i = 0; i < n; i++) begin
            vs = 1'b0;
            tick();
            vs = 1'b1;
            repeat (3) tick();
        end
    endtask

    task automatic do_press();
        START = 1'b1;
        tick();
        tick();
        START = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        tick();
    endtask

    // One-cycle overlap mid-frame, followed by the frame that closes it.
    task automatic do_hit_frame();
        px_dinosaur = 1'b1;
        px_obstacle = 1'b1;
        tick();
        px_dinosaur = 1'b0;
        px_obstacle = 1'b0;
        tick();
        do_frames(1);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        RESET       = 1'b1;
        START       = 1'b0;
        vs          = 1'b1;
        px_dinosaur = 1'b0;
        px_obstacle = 1'b0;

        //             op         arg   st    ov    sp     sc       hi
        vecs[0]  = '{OP_RST,    0,    1'b0, 1'b0, 4'd1,  16'd0,   16'd0};
        vecs[1]  = '{OP_PRESS,  0,    1'b1, 1'b0, 4'd1,  16'd0,   16'd0};
        vecs[2]  = '{OP_FRAMES, 60,   1'b1, 1'b0, 4'd1,  16'd10,  16'd0};
        vecs[3]  = '{OP_PRESS,  0,    1'b1, 1'b0, 4'd1,  16'd10,  16'd0};
        vecs[4]  = '{OP_FRAMES, 162,  1'b1, 1'b0, 4'd1,  16'd37,  16'd0};
        vecs[5]  = '{OP_HIT,    0,    1'b0, 1'b1, 4'd1,  16'd37,  16'd37};
        vecs[6]  = '{OP_FRAMES, 10,   1'b0, 1'b1, 4'd1,  16'd37,  16'd37};
        vecs[7]  = '{OP_PRESS,  0,    1'b0, 1'b1, 4'd1,  16'd37,  16'd37};
        vecs[8]  = '{OP_FRAMES, 50,   1'b0, 1'b1, 4'd1,  16'd37,  16'd37};
        vecs[9]  = '{OP_PRESS,  0,    1'b1, 1'b0, 4'd1,  16'd0,   16'd37};
        vecs[10] = '{OP_FRAMES, 300,  1'b1, 1'b0, 4'd2,  16'd50,  16'd37};
        vecs[11] = '{OP_FRAMES, 3000, 1'b1, 1'b0, 4'd12, 16'd550, 16'd37};
        vecs[12] = '{OP_FRAMES, 300,  1'b1, 1'b0, 4'd12, 16'd600, 16'd37};
        vecs[13] = '{OP_HIT,    0,    1'b0, 1'b1, 4'd12, 16'd600, 16'd600};
        vecs[14] = '{OP_FRAMES, 60,   1'b0, 1'b1, 4'd12, 16'd600, 16'd600};
        vecs[15] = '{OP_PRESS,  0,    1'b1, 1'b0, 4'd1,  16'd0,   16'd600};
        vecs[16] = '{OP_FRAMES, 59,   1'b1, 1'b0, 4'd1,  16'd9,   16'd600};
        vecs[17] = '{OP_HIT,    0,    1'b0, 1'b1, 4'd1,  16'd9,   16'd600};
        vecs[18] = '{OP_FRAMES, 60,   1'b0, 1'b1, 4'd1,  16'd9,   16'd600};
        vecs[19] = '{OP_PRESS,  0,    1'b1, 1'b0, 4'd1,  16'd0,   16'd600};
        vecs[20] = '{OP_FRAMES, 1200, 1'b1, 1'b0, 4'd5,  16'd200, 16'd600};
        vecs[21] = '{OP_RST,    0,    1'b0, 1'b0, 4'd1,  16'd0,   16'd0};

        tick();

        for (int v = 0; v < NVEC; v++) begin
            case (vecs[v].op)
                OP_RST:    do_reset();
                OP_PRESS:  do_press();
                OP_FRAMES: do_frames(vecs[v].arg);
                default:   do_hit_frame();
            endcase
            chk($sformatf("v%0d game_status", v), int'(game_status), int'(vecs[v].st));
            chk($sformatf("v%0d game_over", v),   int'(game_over),   int'(vecs[v].ov));
            chk($sformatf("v%0d speed", v),       int'(speed),       int'(vecs[v].sp));
            chk($sformatf("v%0d score", v),       int'(score),       int'(vecs[v].sc));
            chk($sformatf("v%0d high_score", v),  int'(high_score),  int'(vecs[v].hi));
            $display("[TB] vec %0d op=%0d arg=%0d -> st=%0d ov=%0d sp=%0d sc=%0d hi=%0d",
                     v, vecs[v].op, vecs[v].arg, game_status, game_over, speed, score, high_score);
        end

        // START held through reset must not start the game.
        START = 1'b1;
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        tick();
        tick();
        chk("held_start_after_reset", int'(game_status), 0);
        $display("[TB] seq held START over reset: st=%0d", game_status);
        START = 1'b0;
        tick();

        // Start latency: not yet running before the edge, running two cycles on.
        START = 1'b1;
        chk("start_before_edge", int'(game_status), 0);
        tick();
        tick();
        chk("start_latency", int'(game_status), 1);
        chk("start_speed", int'(speed), 1);
        chk("start_score", int'(score), 0);
        $display("[TB] seq start latency: st=%0d sp=%0d sc=%0d", game_status, speed, score);

        // START kept high while running: no effect, score advances normally.
        do_frames(12);
        chk("run_held_start_score", int'(score), 2);
        $display("[TB] seq run 12 frames START high: sc=%0d", score);

        // Overlap in the very cycle of the frame tick still ends the game.
        px_dinosaur = 1'b1;
        px_obstacle = 1'b1;
        vs = 1'b0;
        tick();
        px_dinosaur = 1'b0;
        px_obstacle = 1'b0;
        vs = 1'b1;
        tick();
        chk("tick_hit_over", int'(game_over), 1);
        chk("tick_hit_score", int'(score), 2);
        chk("tick_hit_high", int'(high_score), 2);
        $display("[TB] seq hit on tick: ov=%0d sc=%0d hi=%0d", game_over, score, high_score);

        // START still high past the hold time: no edge, so no restart.
        do_frames(70);
        chk("held_start_dead_over", int'(game_over), 1);
        chk("held_start_dead_status", int'(game_status), 0);
        $display("[TB] seq held START in DEAD: st=%0d ov=%0d", game_status, game_over);

        // A fresh press restarts exactly once.
        START = 1'b0;
        tick();
        START = 1'b1;
        tick();
        tick();
        chk("restart_status", int'(game_status), 1);
        chk("restart_score", int'(score), 0);
        chk("restart_high", int'(high_score), 2);
        $display("[TB] seq restart: st=%0d sc=%0d hi=%0d", game_status, score, high_score);
        START = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
